fpu_cmd_seq: RTL and testbench

- Command sequencer that drives the fpu top-level port protocol from a simple valid/ready command stream and returns results on a response handshake.
- It generates the fpu's register-file write, operand-load (ld), opcode, enable and act sequencing, then waits for done with a timeout.
- It captures the per-operation exception/compare flags and keeps sticky accumulated flags.
- It sits between a host/bus adapter and the fpu instance.

---
 rtl/fpu_cmd_seq_if.sv | 38 +++
 rtl/fpu_cmd_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_cmd_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// fpu_cmd_seq_if
// Host-side command/response bundle for the fpu command sequencer.
//   cmd_*      : command stream (valid/ready), op, operand/dest addresses,
//                immediate data and rounding mode
//   resp_*     : response stream (valid/ready), error and per-op flags
//   acc_flags  : sticky {inv,div_zero,ov,un,inexact}
//   flags_clr  : clears acc_flags
// master = host / bus adapter, slave = sequencer.
// ---------------------------------------------------------------------------
interface fpu_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_a;
  logic [4:0]  cmd_b;
  logic [4:0]  cmd_d;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_rm;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [7:0]  resp_flags;
  logic [4:0]  acc_flags;
  logic        flags_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, cmd_data, cmd_rm,
    output resp_ready, flags_clr,
    input  cmd_ready, resp_valid, resp_err, resp_flags, acc_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, cmd_data, cmd_rm,
    input  resp_ready, flags_clr,
    output cmd_ready, resp_valid, resp_err, resp_flags, acc_flags
  );
endinterface

// File: rtl/fpu_cmd_seq.sv
// ---------------------------------------------------------------------------
// fpu_cmd_seq
// Turns a valid/ready command stream into the fpu port sequence
// (register-file write, operand load, sync, execute) and returns a response
// with per-op flags plus sticky exception flags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   host            : command/response bundle (fpu_cmd_seq_if.slave)
//   fpu_inp         : write data to the fpu register file
//   fpu_addr1..3    : fpu address ports
//   fpu_opcode      : fpu opcode_in
//   fpu_enable/ld/act, fpu_round : fpu control
//   fpu_done, fpu_<flag> : completion and flag inputs from the fpu
// All outputs are registered; the value seen during a state's cycles is set
// on the edge that enters that state.
// ---------------------------------------------------------------------------
module fpu_cmd_seq #(
  parameter logic [4:0]  SCRATCH_ADDR = 5'd31,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  fpu_cmd_seq_if.slave host,
  output logic [31:0] fpu_inp,
  output logic [4:0]  fpu_addr1,
  output logic [4:0]  fpu_addr2,
  output logic [4:0]  fpu_addr3,
  output logic [2:0]  fpu_opcode,
  output logic        fpu_enable,
  output logic        fpu_ld,
  output logic        fpu_act,
  output logic [2:0]  fpu_round,
  input  logic        fpu_done,
  input  logic        fpu_ov,
  input  logic        fpu_un,
  input  logic        fpu_inv,
  input  logic        fpu_inexact,
  input  logic        fpu_div_zero,
  input  logic        fpu_eq,
  input  logic        fpu_less,
  input  logic        fpu_great
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    LOAD  = 3'd2,
    SYNC  = 3'd3,
    EXEC  = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [4:0]    a_r;
  logic [4:0]    d_r;
  logic          cmd_ready_r;
  logic          resp_valid_r;
  logic          resp_err_r;
  logic [7:0]    resp_flags_r;
  logic [4:0]    acc_flags_r;
  logic [31:0]   fpu_inp_r;
  logic [4:0]    fpu_addr1_r;
  logic [4:0]    fpu_addr2_r;
  logic [4:0]    fpu_addr3_r;
  logic [2:0]    fpu_opcode_r;
  logic          fpu_enable_r;
  logic          fpu_ld_r;
  logic          fpu_act_r;
  logic [2:0]    fpu_round_r;

  logic          accept_s;
  logic          compute_ok_s;
  logic [4:0]    exc_s;
  logic [7:0]    op_flags_s;

  assign accept_s     = host.cmd_valid & cmd_ready_r;
  assign compute_ok_s = (host.cmd_op <= 3'd4) && (host.cmd_d != SCRATCH_ADDR);
  assign exc_s        = {fpu_inv, fpu_div_zero, fpu_ov, fpu_un, fpu_inexact};
  assign op_flags_s   = {fpu_great, fpu_less, fpu_eq, exc_s};

  // Sequencer FSM: state, fpu port drive, response and sticky-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      a_r          <= 5'd0;
      d_r          <= 5'd0;
      cmd_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_flags_r <= 8'd0;
      acc_flags_r  <= 5'd0;
      fpu_inp_r    <= 32'd0;
      fpu_addr1_r  <= 5'd0;
      fpu_addr2_r  <= 5'd0;
      fpu_addr3_r  <= 5'd0;
      fpu_opcode_r <= 3'd0;
      fpu_enable_r <= 1'b1;
      fpu_ld_r     <= 1'b1;
      fpu_act_r    <= 1'b0;
      fpu_round_r  <= 3'd0;
    end else begin
      // Clear may be overridden below by an EXEC-done capture (set wins).
      if (host.flags_clr) begin
        acc_flags_r <= 5'd0;
      end
      case (state_r)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            a_r         <= host.cmd_a;
            d_r         <= host.cmd_d;
            if (host.cmd_op == 3'd5) begin
              // enable=0/ld=0 is the fpu register-file write mode
              state_r      <= WRITE;
              fpu_enable_r <= 1'b0;
              fpu_ld_r     <= 1'b0;
              fpu_addr1_r  <= host.cmd_d;
              fpu_inp_r    <= host.cmd_data;
            end else if (compute_ok_s) begin
              state_r      <= LOAD;
              cnt_r        <= '0;
              fpu_enable_r <= 1'b1;
              fpu_ld_r     <= 1'b1;
              fpu_addr1_r  <= host.cmd_a;
              fpu_addr2_r  <= host.cmd_b;
              fpu_opcode_r <= host.cmd_op;
              fpu_round_r  <= host.cmd_rm;
              fpu_act_r    <= 1'b1;
            end else begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_flags_r <= 8'd0;
            end
          end
        end
        WRITE: begin
          state_r      <= RESP;
          fpu_enable_r <= 1'b1;
          fpu_ld_r     <= 1'b1;
          fpu_inp_r    <= 32'd0;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_flags_r <= 8'd0;
        end
        LOAD: begin
          // Two cycles to cover the register-file read latency
          if (cnt_r == CNT_ONE) begin
            state_r      <= SYNC;
            fpu_enable_r <= 1'b0;
            fpu_ld_r     <= 1'b0;
            fpu_addr1_r  <= SCRATCH_ADDR;
            fpu_inp_r    <= 32'd0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        SYNC: begin
          // Dummy scratch write clears the fpu done counter
          state_r      <= EXEC;
          cnt_r        <= '0;
          fpu_enable_r <= 1'b1;
          fpu_ld_r     <= 1'b0;
          fpu_addr1_r  <= a_r;
          fpu_addr3_r  <= d_r;
        end
        EXEC: begin
          if (fpu_done) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_flags_r <= op_flags_s;
            acc_flags_r  <= (host.flags_clr ? 5'd0 : acc_flags_r) | exc_s;
            fpu_enable_r <= 1'b1;
            fpu_ld_r     <= 1'b1;
            fpu_act_r    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_flags_r <= 8'd0;
            fpu_enable_r <= 1'b1;
            fpu_ld_r     <= 1'b1;
            fpu_act_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RESP: begin
          if (host.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            cmd_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          cmd_ready_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          fpu_enable_r <= 1'b1;
          fpu_ld_r     <= 1'b1;
          fpu_act_r    <= 1'b0;
        end
      endcase
    end
  end

  assign host.cmd_ready  = cmd_ready_r;
  assign host.resp_valid = resp_valid_r;
  assign host.resp_err   = resp_err_r;
  assign host.resp_flags = resp_flags_r;
  assign host.acc_flags  = acc_flags_r;
  assign fpu_inp         = fpu_inp_r;
  assign fpu_addr1       = fpu_addr1_r;
  assign fpu_addr2       = fpu_addr2_r;
  assign fpu_addr3       = fpu_addr3_r;
  assign fpu_opcode      = fpu_opcode_r;
  assign fpu_enable      = fpu_enable_r;
  assign fpu_ld          = fpu_ld_r;
  assign fpu_act         = fpu_act_r;
  assign fpu_round       = fpu_round_r;

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_fpu_cmd_seq
// Directed bench for fpu_cmd_seq with a small behavioural fpu model
// (register file, operand load, done after a programmable delay, flags).
// ---------------------------------------------------------------------------
module tb_fpu_cmd_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_cmd_seq_if host_if ();

  logic [31:0] fpu_inp;
  logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
  logic [2:0]  fpu_opcode, fpu_round;
  logic        fpu_enable, fpu_ld, fpu_act;
  logic        fpu_done, fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero;
  logic        fpu_eq, fpu_less, fpu_great;

  fpu_cmd_seq dut (
    .clk(clk), .rst(rst), .host(host_if),
    .fpu_inp(fpu_inp), .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2),
    .fpu_addr3(fpu_addr3), .fpu_opcode(fpu_opcode), .fpu_enable(fpu_enable),
    .fpu_ld(fpu_ld), .fpu_act(fpu_act), .fpu_round(fpu_round),
    .fpu_done(fpu_done), .fpu_ov(fpu_ov), .fpu_un(fpu_un), .fpu_inv(fpu_inv),
    .fpu_inexact(fpu_inexact), .fpu_div_zero(fpu_div_zero), .fpu_eq(fpu_eq),
    .fpu_less(fpu_less), .fpu_great(fpu_great)
  );

  // ---------------- behavioural fpu model ----------------
  logic [31:0] mem [32];
  logic [31:0] opa = 32'd0, opb = 32'd0, mres;
  logic [2:0]  opc = 3'd0;
  logic [4:0]  mcnt = 5'd0;
  logic [7:0]  mflags;
  int          done_lat = 0;
  bit          hang = 1'b0;
  bit          done_force = 1'b0;
  logic        exec_mode, mdone;
  real         ra, rb, rr;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign exec_mode = fpu_enable & ~fpu_ld & fpu_act;
  assign mdone     = exec_mode && !hang && (int'(mcnt) == done_lat);
  assign fpu_done  = mdone | done_force;
  assign {fpu_great, fpu_less, fpu_eq, fpu_inv, fpu_div_zero, fpu_ov, fpu_un, fpu_inexact} = mflags;

  always_comb begin
    ra = f2r(opa);
    rb = f2r(opb);
    rr = 0.0;
    mflags = 8'd0;
    case (opc)
      3'd0: rr = ra + rb;
      3'd1: rr = ra * rb;
      3'd2: if (rb == 0.0) mflags[3] = 1'b1; else rr = ra / rb;
      3'd3: if (ra < 0.0) mflags[4] = 1'b1; else rr = $sqrt(ra);
      3'd4: begin
        mflags[7] = ra > rb;
        mflags[6] = ra < rb;
        mflags[5] = ra == rb;
      end
      default: rr = 0.0;
    endcase
    mres = r2f(rr);
  end

  always_ff @(posedge clk) begin
    if (!fpu_enable && !fpu_ld) begin
      mem[fpu_addr1] <= fpu_inp;
      mcnt <= 5'd0;
    end else if (exec_mode) begin
      mcnt <= mcnt + 5'd1;
    end
    if (fpu_enable && fpu_ld && fpu_act) begin
      opa <= mem[fpu_addr1];
      opb <= mem[fpu_addr2];
      opc <= fpu_opcode;
    end
    if (mdone) mem[fpu_addr3] <= mres;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int got_lat, got_act;
  bit clr_hold = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!host_if.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_cmd_ready"}, 32'(host_if.cmd_ready), 32'd1);
  endtask

  // Issue one command, then count cycles (and fpu_act cycles) until resp_valid.
  task automatic send(input string nm, input logic [2:0] op, input logic [4:0] a, b, d,
                      input logic [31:0] data, input logic [2:0] rm);
    wait_ready(nm);
    host_if.cmd_op = op; host_if.cmd_a = a; host_if.cmd_b = b; host_if.cmd_d = d;
    host_if.cmd_data = data; host_if.cmd_rm = rm; host_if.cmd_valid = 1'b1;
    host_if.flags_clr = clr_hold;
    @(posedge clk);
    got_lat = 0;
    got_act = 0;
    do begin
      @(negedge clk);
      host_if.cmd_valid = 1'b0;
      got_lat++;
      if (fpu_act) got_act++;
    end while (!host_if.resp_valid && got_lat < 60);
    host_if.flags_clr = 1'b0;
  endtask

  task automatic ack(input string nm);
    host_if.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_if.resp_ready = 1'b0;
    check({nm, "_resp_drop"}, 32'(host_if.resp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  a, b, d;
    logic [31:0] data;
    int          dly;
    int          lat;
    int          act;
    logic        err;
    logic [7:0]  flags;
    logic [4:0]  acc;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] a, b, d,
                              input logic [31:0] data, input int dly, lat, act,
                              input logic err, input logic [7:0] flags, input logic [4:0] acc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.d = d; v.data = data; v.dly = dly;
    v.lat = lat; v.act = act; v.err = err; v.flags = flags; v.acc = acc;
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // compute latency = dly + 5, act cycles = dly + 4 (LOAD 2 + SYNC 1 + EXEC dly+1)
    vt[0]  = mk(3'd5, 5'd0, 5'd0, 5'd1,  32'h3F800000, 0, 2, 0, 1'b0, 8'h00, 5'h00);
    vt[1]  = mk(3'd5, 5'd0, 5'd0, 5'd2,  32'h40000000, 0, 2, 0, 1'b0, 8'h00, 5'h00);
    vt[2]  = mk(3'd5, 5'd0, 5'd0, 5'd4,  32'h3F800000, 0, 2, 0, 1'b0, 8'h00, 5'h00);
    vt[3]  = mk(3'd5, 5'd0, 5'd0, 5'd5,  32'h00000000, 0, 2, 0, 1'b0, 8'h00, 5'h00);
    vt[4]  = mk(3'd0, 5'd1, 5'd2, 5'd3,  32'h0,        2, 7, 6, 1'b0, 8'h00, 5'h00);
    vt[5]  = mk(3'd1, 5'd3, 5'd4, 5'd6,  32'h0,        0, 5, 4, 1'b0, 8'h00, 5'h00);
    vt[6]  = mk(3'd2, 5'd1, 5'd5, 5'd7,  32'h0,        1, 6, 5, 1'b0, 8'h08, 5'h08);
    vt[7]  = mk(3'd0, 5'd1, 5'd2, 5'd8,  32'h0,        0, 5, 4, 1'b0, 8'h00, 5'h08);
    vt[8]  = mk(3'd4, 5'd1, 5'd2, 5'd9,  32'h0,        3, 8, 7, 1'b0, 8'h40, 5'h08);
    vt[9]  = mk(3'd6, 5'd1, 5'd2, 5'd9,  32'h0,        0, 1, 0, 1'b1, 8'h00, 5'h08);
    vt[10] = mk(3'd7, 5'd1, 5'd2, 5'd9,  32'h0,        0, 1, 0, 1'b1, 8'h00, 5'h08);
    vt[11] = mk(3'd0, 5'd1, 5'd2, 5'd31, 32'h0,        0, 1, 0, 1'b1, 8'h00, 5'h08);
    vt[12] = mk(3'd5, 5'd0, 5'd0, 5'd11, 32'hBF800000, 0, 2, 0, 1'b0, 8'h00, 5'h08);

    host_if.cmd_valid = 1'b0; host_if.cmd_op = 3'd0; host_if.cmd_a = 5'd0;
    host_if.cmd_b = 5'd0; host_if.cmd_d = 5'd0; host_if.cmd_data = 32'd0;
    host_if.cmd_rm = 3'd0; host_if.resp_ready = 1'b0; host_if.flags_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd0);
    check("rst_resp_valid", 32'(host_if.resp_valid), 32'd0);
    check("rst_fpu_enable", 32'(fpu_enable), 32'd1);
    check("rst_fpu_ld", 32'(fpu_ld), 32'd1);
    check("rst_fpu_act", 32'(fpu_act), 32'd0);
    check("rst_acc", 32'(host_if.acc_flags), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      done_lat = vt[i].dly;
      send($sformatf("v%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].data, 3'd0);
      check($sformatf("v%0d_lat", i), 32'(got_lat), 32'(vt[i].lat));
      check($sformatf("v%0d_act", i), 32'(got_act), 32'(vt[i].act));
      check($sformatf("v%0d_err", i), 32'(host_if.resp_err), 32'(vt[i].err));
      check($sformatf("v%0d_flags", i), 32'(host_if.resp_flags), 32'(vt[i].flags));
      check($sformatf("v%0d_acc", i), 32'(host_if.acc_flags), 32'(vt[i].acc));
      ack($sformatf("v%0d", i));
    end

    // results landed at the destinations driven on fpu_addr3
    check("add_result_d3", mem[3], 32'h40400000);
    check("mul_result_d6", mem[6], 32'h40400000);

    // sqrt(-1) with flags_clr held through the done cycle: old div_zero
    // cleared, new inv recorded
    done_lat = 0;
    clr_hold = 1'b1;
    send("sqrt_clr", 3'd3, 5'd11, 5'd0, 5'd12, 32'h0, 3'd0);
    clr_hold = 1'b0;
    check("sqrt_flags", 32'(host_if.resp_flags), 32'h10);
    check("sqrt_acc", 32'(host_if.acc_flags), 32'h10);
    ack("sqrt_clr");

    // timeout: 15 EXEC cycles, no done
    hang = 1'b1;
    send("tmo", 3'd0, 5'd1, 5'd2, 5'd10, 32'h0, 3'd0);
    check("tmo_lat", 32'(got_lat), 32'd19);
    check("tmo_act", 32'(got_act), 32'd18);
    check("tmo_err", 32'(host_if.resp_err), 32'd1);
    check("tmo_flags", 32'(host_if.resp_flags), 32'd0);
    check("tmo_acc", 32'(host_if.acc_flags), 32'h10);
    ack("tmo");
    hang = 1'b0;

    // flags_clr pulse
    host_if.flags_clr = 1'b1;
    @(negedge clk);
    host_if.flags_clr = 1'b0;
    check("clr_acc", 32'(host_if.acc_flags), 32'd0);

    // response stall: held stable for 5 cycles
    send("stall", 3'd6, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), 32'(host_if.resp_valid), 32'd1);
      check($sformatf("stall%0d_err", k), 32'(host_if.resp_err), 32'd1);
      check($sformatf("stall%0d_ready", k), 32'(host_if.cmd_ready), 32'd0);
    end
    ack("stall");

    // done outside EXEC is ignored
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    done_force = 1'b0;
    check("idle_done_valid", 32'(host_if.resp_valid), 32'd0);
    check("idle_done_acc", 32'(host_if.acc_flags), 32'd0);

    // reset while in EXEC
    hang = 1'b1;
    wait_ready("rst_exec");
    host_if.cmd_op = 3'd0; host_if.cmd_a = 5'd1; host_if.cmd_b = 5'd2;
    host_if.cmd_d = 5'd13; host_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !exec_mode; k++) @(negedge clk);
    check("rst_exec_reached", 32'(exec_mode), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec_valid", 32'(host_if.resp_valid), 32'd0);
    check("rst_exec_enable", 32'(fpu_enable), 32'd1);
    check("rst_exec_ld", 32'(fpu_ld), 32'd1);
    check("rst_exec_act", 32'(fpu_act), 32'd0);
    check("rst_exec_ready", 32'(host_if.cmd_ready), 32'd0);
    rst = 1'b0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(host_if.cmd_ready), 32'd1);
    check("post_rst_valid", 32'(host_if.resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
